// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multicycle CPU: FSM states, opcodes, mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [1:0] PCSRC_PC4    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] ALUB_RT     = 2'd0;
    localparam logic [1:0] ALUB_FOUR   = 2'd1;
    localparam logic [1:0] ALUB_IMM    = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    // All datapath strobes bundled so they can be defaulted and gated as one word.
    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       fault;
    } ctrl_t;

    // States that sit on a memory handshake and are therefore guarded by the timeout.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/pc_control_fsm.sv
// Multicycle fetch/decode/execute control FSM owning PC update and datapath strobes.
// Latency: R/ADDI 4, LW 5, SW 4, BEQ 3, J 3 cycles with mem_ready high; outputs combinational from state.
// Backpressure: memory states stall on mem_ready low; TIMEOUT_CYCLES waiting cycles force FAULT.
module pc_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic       irWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic       iorD,
    output logic       regWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       fault,
    output logic [3:0] state_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic       w_timeout;
    ctrl_t      w_ctrl;
    ctrl_t      w_out;

    // Last permitted waiting cycle without mem_ready; a ready in the same cycle still wins.
    assign w_timeout = (r_wait_cnt == TIMEOUT_LAST) && !mem_ready;

    // State register and wait counter; counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (is_wait_state(r_state))
                r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Next-state and strobe decode; only pcWrite/irWrite depend on mem_ready/zero.
    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = ALUB_FOUR;
                w_ctrl.alu_op    = ALUOP_ADD;
                if (mem_ready) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_ctrl.pc_src   = PCSRC_PC4;
                    w_next          = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while the opcode is decoded.
                w_ctrl.alu_src_b = ALUB_IMM_SH;
                w_ctrl.alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_RTYPE:     w_next = S_EXEC_R;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_EXEC_I;
                    OP_HALT:      w_next = S_HALT;
                    default:      w_next = S_FAULT;
                endcase
            end
            S_EXEC_R: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALUB_RT;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_next           = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALUB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_next           = S_ALU_WB;
            end
            S_ALU_WB: begin
                // IR still holds the instruction, so it picks rd (R-type) or rt (ADDI).
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = (opcode == OP_RTYPE);
                w_next           = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALUB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_next           = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
                if (mem_ready)      w_next = S_MEM_WB;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_MEM_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_next            = S_FETCH;
            end
            S_MEM_WR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALUB_RT;
                w_ctrl.alu_op    = ALUOP_SUB;
                w_ctrl.pc_write  = zero;
                w_ctrl.pc_src    = PCSRC_ALUOUT;
                w_next           = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl.pc_write = 1'b1;
                w_ctrl.pc_src   = PCSRC_JUMP;
                w_next          = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            S_FAULT: w_ctrl.fault = 1'b1;
            default: w_next = S_FAULT;
        endcase
    end

    // Everything is forced idle while reset is held, whatever state is still registered.
    assign w_out = reset ? w_ctrl : '0;

    assign pcWrite  = w_out.pc_write;
    assign pcSrc    = w_out.pc_src;
    assign irWrite  = w_out.ir_write;
    assign memRead  = w_out.mem_read;
    assign memWrite = w_out.mem_write;
    assign iorD     = w_out.iord;
    assign regWrite = w_out.reg_write;
    assign memToReg = w_out.mem_to_reg;
    assign regDst   = w_out.reg_dst;
    assign aluSrcA  = w_out.alu_src_a;
    assign aluSrcB  = w_out.alu_src_b;
    assign aluOp    = w_out.alu_op;
    assign fault    = w_out.fault;
    assign state_o  = r_state;

endmodule
